iterative_shifter: RTL and testbench

ITERATIVE_SHIFTER -- requirements
Module: iterative_shifter

---
 rtl/iterative_shifter.sv | 92 +++++++++
 tb/tb_iterative_shifter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/iterative_shifter.sv
// Multi-cycle shifter: one bit per cycle in SHIFT, mode latched at start.
// busy/done are flops loaded from the next-state decode so every output is registered.
module iterative_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  typedef enum logic [1:0] {
    M_SLL = 2'b00,
    M_SRL = 2'b01,
    M_SRA = 2'b10,
    M_ROL = 2'b11
  } mode_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   work, work_nxt;
  logic [SHAMT_W-1:0] cnt, cnt_nxt;
  mode_t              mode_q, mode_nxt;
  logic [WIDTH-1:0]   work_step;

  // Single-bit step; SRA replicates the MSB, which never changes during SRA.
  always_comb begin
    work_step = work;
    case (mode_q)
      M_SLL:   work_step = {work[WIDTH-2:0], 1'b0};
      M_SRL:   work_step = {1'b0, work[WIDTH-1:1]};
      M_SRA:   work_step = {work[WIDTH-1], work[WIDTH-1:1]};
      M_ROL:   work_step = {work[WIDTH-2:0], work[WIDTH-1]};
      default: work_step = work;
    endcase
  end

  always_comb begin
    state_nxt = state;
    work_nxt  = work;
    cnt_nxt   = cnt;
    mode_nxt  = mode_q;
    case (state)
      IDLE: begin
        if (start) begin
          work_nxt  = data_in;
          cnt_nxt   = shamt;
          mode_nxt  = mode_t'(mode);
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt != '0) begin
          work_nxt = work_step;
          cnt_nxt  = cnt - 1'b1;
        end else begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      work   <= '0;
      cnt    <= '0;
      mode_q <= M_SLL;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      work   <= work_nxt;
      cnt    <= cnt_nxt;
      mode_q <= mode_nxt;
      busy   <= (state_nxt == SHIFT);
      done   <= (state_nxt == DONE);
    end
  end

  assign result = work;

endmodule

// File: tb/tb_iterative_shifter.sv
// Scoreboard bench for iterative_shifter: expected results queued at drive time,
// popped by a monitor on each done pulse.
module tb_iterative_shifter;
  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [1:0]         mode;
  logic [WIDTH-1:0]   data_in;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;

  iterative_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .data_in(data_in),
    .shamt(shamt), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [WIDTH-1:0] sb[$];
  int done_cyc[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [WIDTH-1:0] model(input logic [1:0] m, input logic [WIDTH-1:0] d,
                                             input int n);
    case (m)
      2'b00:   return d << n;
      2'b01:   return d >> n;
      2'b10:   return WIDTH'($signed(d) >>> n);
      default: return (n == 0) ? d : ((d << n) | (d >> (WIDTH - n)));
    endcase
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (done) begin
      chk("busy_with_done", busy, 1'b0);
      done_cyc.push_back(cyc);
      if (sb.size() == 0) chk("spurious_done", 1'b1, 1'b0);
      else                chk("result", result, sb.pop_front());
    end
  end

  // One operation: accept, optional start re-pulse mid-shift, then latency/busy/hold checks.
  task automatic run_op(input logic [1:0] m, input logic [WIDTH-1:0] d, input int n,
                        input bit repulse);
    logic [WIDTH-1:0] exp;
    int lat, bcnt;
    exp = model(m, d, n);
    @(negedge clk);
    mode = m; data_in = d; shamt = SHAMT_W'(n); start = 1'b1;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    start = 1'b0; mode = ~m; data_in = ~d; shamt = ~SHAMT_W'(n);
    lat = 0;
    bcnt = busy ? 1 : 0;
    for (int k = 1; k <= 200; k++) begin
      if (repulse && k == 1) begin start = 1'b1; data_in = 32'hDEADBEEF; end
      if (repulse && k == 2) start = 1'b0;
      @(posedge clk);
      #1;
      if (busy) bcnt++;
      if (done) begin lat = k; break; end
    end
    chk("latency", lat, n + 1);
    chk("busy_cycles", bcnt, n + 1);
    @(posedge clk);
    #1;
    chk("done_one_cycle", done, 1'b0);
    chk("result_hold", result, exp);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 2'b00; data_in = '0; shamt = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 32'h0);
    reset = 1'b0;

    run_op(2'b00, 32'hFFFFFFFF, 2, 1'b0);
    run_op(2'b10, 32'h80000000, 31, 1'b0);
    run_op(2'b01, 32'h80000000, 31, 1'b0);
    run_op(2'b11, 32'h80000000, 1, 1'b0);
    for (int m = 0; m < 4; m++) run_op(2'(m), 32'h12345678, 0, 1'b0);
    run_op(2'b11, 32'hA5000F0F, 31, 1'b0);
    run_op(2'b10, 32'h7000_0001, 4, 1'b0);
    for (int i = 0; i < 6; i++)
      run_op(2'($urandom_range(0, 3)), $urandom, $urandom_range(0, WIDTH - 1), 1'b0);

    // start re-pulsed while shifting: ignored, one done, first result intact
    run_op(2'b00, 32'h0000_00F1, 5, 1'b1);
    repeat (12) @(negedge clk);
    chk("repulse_idle", busy, 1'b0);

    // reset in the third SHIFT cycle aborts without a done
    @(negedge clk);
    mode = 2'b00; data_in = 32'h0000_0ABC; shamt = 5'd10; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_result", result, 32'h0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_sb_empty", sb.size(), 0);

    // reset wins over start on the same edge
    @(negedge clk); reset = 1'b1; start = 1'b1;
    @(posedge clk); #1 reset = 1'b0; start = 1'b0;
    chk("rst_prio_busy", busy, 1'b0);
    @(posedge clk); #1;
    chk("rst_prio_idle", busy, 1'b0);
    run_op(2'b01, 32'hF000_0000, 3, 1'b0);

    // start held high: two back-to-back operations
    done_cyc.delete();
    @(negedge clk);
    mode = 2'b00; data_in = 32'h1; shamt = 5'd1; start = 1'b1;
    sb.push_back(32'h2);
    sb.push_back(32'h1);
    @(posedge clk); #1;
    mode = 2'b01; data_in = 32'h2; shamt = 5'd1;
    begin
      int k;
      for (k = 0; k < 50 && done_cyc.size() < 2; k++) begin
        @(posedge clk); #1;
        if (done_cyc.size() == 1 && busy) start = 1'b0;
      end
    end
    start = 1'b0;
    chk("b2b_count", done_cyc.size(), 2);
    if (done_cyc.size() == 2) chk("b2b_period", done_cyc[1] - done_cyc[0], 4);
    repeat (10) @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
